// File: rtl/thermostat_pkg.sv
// Shared types and constants for the thermostat controller and its helpers.
package thermostat_pkg;
    localparam int         TEMP_W  = 10;
    localparam logic [3:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_HEAT    = 2'd1,
        MODE_COOL    = 2'd2,
        MODE_LOCKOUT = 2'd3
    } mode_e;
endpackage

// File: rtl/bcd3_to_bin.sv
// Combinational 3-digit BCD to binary conversion with a digit-valid flag.
module bcd3_to_bin
    import thermostat_pkg::*;
(
    input  logic [3:0]        huns_i,
    input  logic [3:0]        tens_i,
    input  logic [3:0]        ones_i,
    output logic [TEMP_W-1:0] bin_o,
    output logic              valid_o
);
    assign valid_o = (huns_i <= BCD_MAX) && (tens_i <= BCD_MAX) && (ones_i <= BCD_MAX);

    // Result is only meaningful when valid_o is set; 999 fits in TEMP_W bits.
    assign bin_o = (TEMP_W'(huns_i) * TEMP_W'(100))
                 + (TEMP_W'(tens_i) * TEMP_W'(10))
                 + TEMP_W'(ones_i);
endmodule

// File: rtl/thermostat_ctrl.sv
// Hysteresis heat/cool controller with setpoint capture, minimum-run and lockout timing.
module thermostat_ctrl
    import thermostat_pkg::*;
#(
    parameter int HYST             = 2,
    parameter int MIN_RUN          = 8,
    parameter int LOCKOUT_CYC      = 16,
    parameter int DEFAULT_SETPOINT = 72,
    parameter int CNT_W            = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        entry_state,
    input  logic [3:0]        set_huns,
    input  logic [3:0]        set_tens,
    input  logic [3:0]        set_ones,
    input  logic [TEMP_W-1:0] sensor_temp,
    input  logic              sensor_valid,
    output logic              heat,
    output logic              cool,
    output logic [1:0]        mode,
    output logic [TEMP_W-1:0] setpoint_bin,
    output logic              setpoint_err
);
    localparam logic [CNT_W-1:0]  RUN_LAST  = CNT_W'(MIN_RUN - 1);
    localparam logic [CNT_W-1:0]  LOCK_LAST = CNT_W'(LOCKOUT_CYC - 1);
    localparam logic signed [10:0] HYST_S   = 11'(HYST);

    logic [TEMP_W-1:0] conv_bin;
    logic              conv_valid;

    bcd3_to_bin u_conv (
        .huns_i  (set_huns),
        .tens_i  (set_tens),
        .ones_i  (set_ones),
        .bin_o   (conv_bin),
        .valid_o (conv_valid)
    );

    mode_e             state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [TEMP_W-1:0] setpoint_q, setpoint_d;
    logic [TEMP_W-1:0] temp_q;
    logic              temp_known_q;
    logic              err_q, err_d;
    logic              err_seen_q, err_seen_d;
    logic              heat_q, cool_q;
    logic              entry_idle;

    assign entry_idle = (entry_state == 2'd0);

    // The error pulse fires once per idle period; leaving idle re-arms it.
    always_comb begin
        setpoint_d = setpoint_q;
        err_d      = 1'b0;
        err_seen_d = 1'b0;
        if (entry_idle) begin
            err_seen_d = err_seen_q | ~conv_valid;
            err_d      = ~conv_valid & ~err_seen_q;
            if (conv_valid) begin
                setpoint_d = conv_bin;
            end
        end
    end

    // Signed 11-bit so that setpoint - HYST can go negative without wrapping.
    logic signed [10:0] t_s, s_s, lo_s, hi_s;
    assign t_s  = $signed({1'b0, temp_q});
    assign s_s  = $signed({1'b0, setpoint_q});
    assign lo_s = s_s - HYST_S;
    assign hi_s = s_s + HYST_S;

    assign cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        case (state_q)
            MODE_IDLE: begin
                cnt_d = '0;
                if (temp_known_q && (t_s < lo_s)) begin
                    state_d = MODE_HEAT;
                end else if (temp_known_q && (t_s > hi_s)) begin
                    state_d = MODE_COOL;
                end
            end
            MODE_HEAT: begin
                if ((t_s >= s_s) && (cnt_q >= RUN_LAST)) begin
                    state_d = MODE_LOCKOUT;
                    cnt_d   = '0;
                end
            end
            MODE_COOL: begin
                if ((t_s <= s_s) && (cnt_q >= RUN_LAST)) begin
                    state_d = MODE_LOCKOUT;
                    cnt_d   = '0;
                end
            end
            MODE_LOCKOUT: begin
                if (cnt_q == LOCK_LAST) begin
                    state_d = MODE_IDLE;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = MODE_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= MODE_IDLE;
            cnt_q        <= '0;
            setpoint_q   <= TEMP_W'(DEFAULT_SETPOINT);
            temp_q       <= '0;
            temp_known_q <= 1'b0;
            err_q        <= 1'b0;
            err_seen_q   <= 1'b0;
            heat_q       <= 1'b0;
            cool_q       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            setpoint_q <= setpoint_d;
            err_q      <= err_d;
            err_seen_q <= err_seen_d;
            heat_q     <= (state_d == MODE_HEAT);
            cool_q     <= (state_d == MODE_COOL);
            if (sensor_valid) begin
                temp_q       <= sensor_temp;
                temp_known_q <= 1'b1;
            end
        end
    end

    assign heat         = heat_q;
    assign cool         = cool_q;
    assign mode         = state_q;
    assign setpoint_bin = setpoint_q;
    assign setpoint_err = err_q;
endmodule

// File: tb/tb_thermostat_ctrl.sv
// Directed bench for thermostat_ctrl: per-cycle comparison against a rule-level model plus literal checks.
module tb_thermostat_ctrl;
    localparam int HYST = 2, MIN_RUN = 8, LOCKOUT_CYC = 16, DEF_SP = 72;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] entry_state = 2'd1;
    logic [3:0] set_huns = 4'd0, set_tens = 4'd0, set_ones = 4'd0;
    logic [9:0] sensor_temp = 10'd0;
    logic       sensor_valid = 1'b0;
    logic       heat, cool, setpoint_err;
    logic [1:0] mode;
    logic [9:0] setpoint_bin;

    int checks = 0;
    int errors = 0;

    thermostat_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .entry_state  (entry_state),
        .set_huns     (set_huns),
        .set_tens     (set_tens),
        .set_ones     (set_ones),
        .sensor_temp  (sensor_temp),
        .sensor_valid (sensor_valid),
        .heat         (heat),
        .cool         (cool),
        .mode         (mode),
        .setpoint_bin (setpoint_bin),
        .setpoint_err (setpoint_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Model: modes 0 idle, 1 heat, 2 cool, 3 lockout; m_in = cycles spent in the current mode.
    int m_mode = 0, m_in = 0, m_temp = 0, m_sp = DEF_SP;
    bit m_known = 0, m_err = 0, m_seen = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0; m_in <= 0; m_temp <= 0; m_known <= 0;
            m_sp <= DEF_SP; m_err <= 0; m_seen <= 0;
        end else begin
            case (m_mode)
                0: if (m_known && m_temp < m_sp - HYST) begin m_mode <= 1; m_in <= 1; end
                   else if (m_known && m_temp > m_sp + HYST) begin m_mode <= 2; m_in <= 1; end
                1: if (m_in >= MIN_RUN && m_temp >= m_sp) begin m_mode <= 3; m_in <= 1; end
                   else m_in <= m_in + 1;
                2: if (m_in >= MIN_RUN && m_temp <= m_sp) begin m_mode <= 3; m_in <= 1; end
                   else m_in <= m_in + 1;
                default: if (m_in >= LOCKOUT_CYC) begin m_mode <= 0; m_in <= 0; end
                         else m_in <= m_in + 1;
            endcase
            if (entry_state == 0) begin
                if (set_huns <= 9 && set_tens <= 9 && set_ones <= 9) begin
                    m_sp  <= int'(set_huns) * 100 + int'(set_tens) * 10 + int'(set_ones);
                    m_err <= 0;
                end else begin
                    m_err  <= !m_seen;
                    m_seen <= 1;
                end
            end else begin
                m_err <= 0; m_seen <= 0;
            end
            if (sensor_valid) begin
                m_temp  <= int'(sensor_temp);
                m_known <= 1;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("mode", int'(mode), m_mode);
            check("heat", int'(heat), int'(m_mode == 1));
            check("cool", int'(cool), int'(m_mode == 2));
            check("setpoint_bin", int'(setpoint_bin), m_sp);
            check("setpoint_err", int'(setpoint_err), int'(m_err));
        end
    end

    task automatic set_entry(input logic [1:0] es, input logic [3:0] h, t, o);
        entry_state = es; set_huns = h; set_tens = t; set_ones = o;
    endtask

    task automatic strobe(input int temp);
        sensor_temp = 10'(temp); sensor_valid = 1'b1;
        @(negedge clk);
        sensor_valid = 1'b0;
    endtask

    task automatic wait_mode(input int m, input int budget, input string name);
        int n = 0;
        while (int'(mode) != m && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(mode), m);
    endtask

    // Counts cycles spent in mode m, optionally strobing a sensor value on given cycles of the stay.
    task automatic count_state(input int m, input int at1, input int t1,
                               input int at2, input int t2, output int n);
        n = 0;
        while (int'(mode) == m && n < 300) begin
            sensor_valid = 1'b0;
            if (n + 1 == at1) begin sensor_temp = 10'(t1); sensor_valid = 1'b1; end
            if (n + 1 == at2) begin sensor_temp = 10'(t2); sensor_valid = 1'b1; end
            n++;
            @(negedge clk);
        end
        sensor_valid = 1'b0;
    endtask

    int n, pulses;

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_mode", int'(mode), 0);
        check("reset_setpoint", int'(setpoint_bin), 72);
        check("reset_err", int'(setpoint_err), 0);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("idle_hold_mode", int'(mode), 0);
            check("idle_hold_sp", int'(setpoint_bin), 72);
        end

        // Heat run: setpoint 65, sensor 60, sensor 65 on run cycle 3.
        set_entry(2'd0, 4'd0, 4'd6, 4'd5);
        strobe(60);
        check("sp_65", int'(setpoint_bin), 65);
        wait_mode(1, 5, "enter_heat");
        count_state(1, 3, 65, 0, 0, n);
        check("heat_len", n, 8);
        count_state(3, 0, 0, 0, 0, n);
        check("lockout_len", n, 16);
        check("idle_after_lock", int'(mode), 0);

        // Cool run with lockout ignoring temperature.
        set_entry(2'd0, 4'd0, 4'd7, 4'd0);
        strobe(75);
        wait_mode(2, 5, "enter_cool");
        count_state(2, 2, 71, 10, 70, n);
        check("cool_len", n, 11);
        count_state(3, 5, 80, 0, 0, n);
        check("lockout_ignores_temp", n, 16);
        wait_mode(2, 3, "recool");
        count_state(2, 1, 70, 0, 0, n);
        check("cool_min_run", n, 8);
        count_state(3, 0, 0, 0, 0, n);
        check("lockout2_len", n, 16);

        // Hysteresis band around 70.
        strobe(68);
        repeat (4) @(negedge clk);
        check("hyst_68_idle", int'(mode), 0);
        strobe(72);
        repeat (4) @(negedge clk);
        check("hyst_72_idle", int'(mode), 0);
        strobe(67);
        wait_mode(1, 5, "hyst_67_heat");
        count_state(1, 1, 70, 0, 0, n);
        check("heat2_len", n, 8);
        count_state(3, 0, 0, 0, 0, n);
        check("lockout3_len", n, 16);

        // Partial entry ignored; bad digit pulses once per idle period.
        set_entry(2'd1, 4'd9, 4'd9, 4'd9);
        repeat (5) @(negedge clk);
        check("entry_hold_sp", int'(setpoint_bin), 70);
        for (int k = 0; k < 2; k++) begin
            set_entry(2'd1, 4'd0, 4'd0, 4'd0);
            @(negedge clk);
            set_entry(2'd0, 4'd0, 4'hA, 4'd0);
            pulses = 0;
            repeat (6) begin
                @(negedge clk);
                pulses += int'(setpoint_err);
            end
            check("err_single_pulse", pulses, 1);
            check("err_hold_sp", int'(setpoint_bin), 70);
        end

        // Setpoint 1: heat threshold is -1, so sensor 0 stays idle.
        set_entry(2'd0, 4'd0, 4'd0, 4'd1);
        strobe(0);
        repeat (5) @(negedge clk);
        check("sp1_idle", int'(mode), 0);
        check("sp1_value", int'(setpoint_bin), 1);
        set_entry(2'd0, 4'd9, 4'd9, 4'd9);
        strobe(999);
        repeat (3) @(negedge clk);
        check("sp999_value", int'(setpoint_bin), 999);
        check("sp999_idle", int'(mode), 0);

        // Asynchronous reset during a heat run.
        set_entry(2'd0, 4'd0, 4'd7, 4'd0);
        strobe(60);
        wait_mode(1, 5, "enter_heat_rst");
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_heat", int'(heat), 0);
        check("async_mode", int'(mode), 0);
        entry_state = 2'd1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_mode", int'(mode), 0);
        check("post_rst_sp", int'(setpoint_bin), 72);
        check("post_rst_heat", int'(heat), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
